// File: rtl/vector_pkg.sv
// Shared constants, state type and helpers for the vector RAM fill path.
package vector_pkg;

    localparam int WORD_W         = 32;
    localparam int LINE_W         = 1024;
    localparam int ADDR_W         = 7;
    localparam int CNT_W          = 8;
    localparam int WORDS_PER_LINE = LINE_W / WORD_W;
    localparam int WIDX_W         = 5;
    localparam int RAM_DEPTH      = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } loader_state_t;

    // A load can never cover more lines than the RAM holds.
    function automatic logic [CNT_W-1:0] clamp_lines(input logic [CNT_W-1:0] n);
        logic [CNT_W-1:0] r;
        if (n > CNT_W'(RAM_DEPTH)) begin
            r = CNT_W'(RAM_DEPTH);
        end else begin
            r = n;
        end
        return r;
    endfunction

endpackage

// File: rtl/line_assembler.sv
// Packs consecutive stream words into one RAM line; line_o already contains
// the word being accepted so the owner can commit it on the same edge.
module line_assembler
    import vector_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              wr_en_i,
    input  logic              close_i,
    input  logic [WORD_W-1:0] data_i,
    output logic [LINE_W-1:0] line_o,
    output logic              full_o
);

    logic [LINE_W-1:0] pack_q;
    logic [LINE_W-1:0] pack_d;
    logic [WIDX_W-1:0] word_idx_q;
    logic [WIDX_W-1:0] word_idx_d;
    logic [LINE_W-1:0] line_s;
    logic              full_s;

    // Merge the incoming word and decide whether the line is complete.
    always_comb begin
        line_s     = pack_q;
        full_s     = 1'b0;
        pack_d     = pack_q;
        word_idx_d = word_idx_q;
        if (wr_en_i) begin
            line_s[int'(word_idx_q) * WORD_W +: WORD_W] = data_i;
            full_s = (word_idx_q == WIDX_W'(WORDS_PER_LINE - 1)) || close_i;
        end else begin
            full_s = 1'b0;
        end
        // A completed line leaves the pack register zeroed, which also
        // provides the zero fill for an early-closed line.
        if (clear_i || full_s) begin
            pack_d     = '0;
            word_idx_d = '0;
        end else if (wr_en_i) begin
            pack_d     = line_s;
            word_idx_d = word_idx_q + WIDX_W'(1);
        end else begin
            pack_d     = pack_q;
            word_idx_d = word_idx_q;
        end
    end

    // Pack register and word index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pack_q     <= '0;
            word_idx_q <= '0;
        end else begin
            pack_q     <= pack_d;
            word_idx_q <= word_idx_d;
        end
    end

    assign line_o = line_s;
    assign full_o = full_s;

endmodule

// File: rtl/vector_ram_loader.sv
// Streams 32-bit words into 1024-bit RAM lines from a programmed base line.
// Optional early end on in_last with zero fill: VECTOR_RAM_LOADER_LAST_PAD_EN.
module vector_ram_loader
    import vector_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_lines,
    output logic              busy,
    output logic              done,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    output logic              ram_write_enable,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [LINE_W-1:0] ram_in,
    output logic [CNT_W-1:0]  lines_written
);

    loader_state_t     state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]  num_q, num_d;
    logic [CNT_W-1:0]  lines_q, lines_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] ram_in_q, ram_in_d;
    logic              busy_q, done_q, in_ready_q;

    logic              handshake_s;
    logic              clear_s;
    logic              close_s;
    logic              line_full_s;
    logic [LINE_W-1:0] line_s;
    logic [CNT_W-1:0]  num_clamped_s;

`ifdef VECTOR_RAM_LOADER_LAST_PAD_EN
    assign close_s = in_last;
`else
    logic unused_in_last_s;
    assign unused_in_last_s = in_last;
    assign close_s          = 1'b0;
`endif

    assign handshake_s   = in_valid && in_ready_q;
    assign num_clamped_s = clamp_lines(num_lines);

    line_assembler u_line_assembler (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (clear_s),
        .wr_en_i (handshake_s),
        .close_i (close_s),
        .data_i  (in_data),
        .line_o  (line_s),
        .full_o  (line_full_s)
    );

    // Next-state, address and line-count logic.
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        num_d    = num_q;
        lines_d  = lines_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        ram_in_d = ram_in_q;
        clear_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    num_d   = num_clamped_s;
                    lines_d = '0;
                    clear_s = 1'b1;
                    if (num_clamped_s == CNT_W'(0)) begin
                        state_d = DONE;
                    end else begin
                        state_d = LOAD;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                if (line_full_s) begin
                    we_d     = 1'b1;
                    addr_d   = base_q + lines_q[ADDR_W-1:0];
                    ram_in_d = line_s;
                    lines_d  = lines_q + CNT_W'(1);
                    if ((lines_q + CNT_W'(1) == num_q) || close_s) begin
                        state_d = FLUSH;
                    end else begin
                        state_d = LOAD;
                    end
                end else begin
                    state_d = LOAD;
                end
            end
            FLUSH:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            base_q     <= '0;
            num_q      <= '0;
            lines_q    <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            ram_in_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            num_q      <= num_d;
            lines_q    <= lines_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            ram_in_q   <= ram_in_d;
            busy_q     <= (state_d == LOAD) || (state_d == FLUSH);
            done_q     <= (state_d == DONE);
            in_ready_q <= (state_d == LOAD);
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign in_ready         = in_ready_q;
    assign ram_write_enable = we_q;
    assign ram_addr         = addr_q;
    assign ram_in           = ram_in_q;
    assign lines_written    = lines_q;

endmodule
